// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock ratio monitors.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        CHECK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } highBounds_t;

    // Acceptable high time: floor(divide/2)-tol .. ceil(divide/2)+tol, never below 1.
    function automatic highBounds_t highBounds(input int unsigned divide, input int unsigned tol);
        highBounds_t b;
        int unsigned half;
        half = divide / 32'd2;
        if (half >= tol + 32'd1) begin
            b.lo = half - tol;
        end else begin
            b.lo = 32'd1;
        end
        b.hi = (divide + 32'd1) / 32'd2 + tol;
        return b;
    endfunction

endpackage

// File: rtl/clk_ratio_monitor_sync.sv
// Two-flop synchronizer with history flop; level and rise pulse are mutually aligned.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);
    logic s1_r;
    logic s2_r;
    logic s3_r;
    logic rise_r;

    // Synchronize the asynchronous input and register its rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            s3_r   <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            s1_r   <= din;
            s2_r   <= s1_r;
            s3_r   <= s2_r;
            rise_r <= s2_r & ~s3_r;
        end
    end

    // s3 is one cycle behind s2, so it lines up with the registered rise.
    assign level = s3_r;
    assign rise  = rise_r;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures a divided clock against clkIn, asserts locked once the ratio is
// stable and latches a sticky fault on any deviation seen while locked.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned DIVIDE     = 32'd3,
    parameter int unsigned TOL        = 32'd0,
    parameter int unsigned LOCK_COUNT = 32'd4,
    parameter int unsigned CNT_W      = 32'd8
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             enable,
    input  logic             divClk,
    input  logic             clearFault,
    output logic             edgeStrobe,
    output logic [CNT_W-1:0] periodOut,
    output logic [CNT_W-1:0] highOut,
    output logic             locked,
    output logic             fault
);
    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 32'd1);
    localparam int unsigned PLO_I  = (DIVIDE > TOL) ? (DIVIDE - TOL) : 32'd0;
    localparam int unsigned PHI_I  = DIVIDE + TOL;
    localparam int unsigned TMO_I  = DIVIDE + TOL + 32'd1;
    localparam int unsigned LM1_I  = LOCK_COUNT - 32'd1;
    localparam highBounds_t HB     = highBounds(DIVIDE, TOL);

    localparam logic [CNT_W-1:0]  PERIOD_LO = PLO_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  PERIOD_HI = PHI_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  TIMEOUT   = TMO_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  HIGH_LO   = HB.lo[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  HIGH_HI   = HB.hi[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [GOOD_W-1:0] GOOD_ZERO = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};
    localparam logic [GOOD_W-1:0] GOOD_LAST = LM1_I[GOOD_W-1:0];

    logic              divLevel_s;
    logic              divRise_s;
    logic              active_s;
    logic              periodGood_s;
    logic              highGood_s;
    logic              timeout_s;
    logic              measure_s;
    logic              good_s;
    logic              bad_s;
    logic              faultSet_s;

    state_t            state_r;
    logic [CNT_W-1:0]  periodCnt_r;
    logic [CNT_W-1:0]  highCnt_r;
    logic [GOOD_W-1:0] goodCnt_r;
    logic [CNT_W-1:0]  periodOut_r;
    logic [CNT_W-1:0]  highOut_r;
    logic              locked_r;
    logic              fault_r;

    sync_edge_detect u_sync (
        .clk   (clkIn),
        .reset (reset),
        .din   (divClk),
        .level (divLevel_s),
        .rise  (divRise_s)
    );

    // Classify the current cycle: measurement, timeout, good/bad and fault set.
    always_comb begin
        active_s     = enable && ((state_r == CHECK) || (state_r == LOCKED));
        periodGood_s = (periodCnt_r >= PERIOD_LO) && (periodCnt_r <= PERIOD_HI);
        highGood_s   = (highCnt_r >= HIGH_LO) && (highCnt_r <= HIGH_HI);
        timeout_s    = (state_r != IDLE) && !divRise_s && (periodCnt_r >= TIMEOUT);
        measure_s    = active_s && divRise_s;
        good_s       = measure_s && periodGood_s && highGood_s;
        bad_s        = (measure_s && !(periodGood_s && highGood_s)) || (active_s && timeout_s);
        faultSet_s   = bad_s && (state_r == LOCKED);
    end

    // Period and high-time counters; a timeout restarts the period window.
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            periodCnt_r <= CNT_ZERO;
            highCnt_r   <= CNT_ZERO;
        end else if (state_r == IDLE) begin
            periodCnt_r <= CNT_ZERO;
            highCnt_r   <= CNT_ZERO;
        end else begin
            if (divRise_s || timeout_s) begin
                periodCnt_r <= CNT_ONE;
            end else if (periodCnt_r != CNT_MAX) begin
                periodCnt_r <= periodCnt_r + CNT_ONE;
            end else begin
                periodCnt_r <= periodCnt_r;
            end
            if (divRise_s) begin
                highCnt_r <= CNT_ONE;
            end else if (divLevel_s && (highCnt_r != CNT_MAX)) begin
                highCnt_r <= highCnt_r + CNT_ONE;
            end else begin
                highCnt_r <= highCnt_r;
            end
        end
    end

    // Lock state machine with registered measurement, lock and sticky fault outputs.
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            goodCnt_r   <= GOOD_ZERO;
            periodOut_r <= CNT_ZERO;
            highOut_r   <= CNT_ZERO;
            locked_r    <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            // Set wins over a simultaneous clear.
            fault_r <= faultSet_s | (fault_r & ~clearFault);
            if (measure_s) begin
                periodOut_r <= periodCnt_r;
                highOut_r   <= highCnt_r;
            end else begin
                periodOut_r <= periodOut_r;
                highOut_r   <= highOut_r;
            end
            if (!enable) begin
                state_r   <= IDLE;
                goodCnt_r <= GOOD_ZERO;
                locked_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r   <= ACQUIRE;
                        goodCnt_r <= GOOD_ZERO;
                        locked_r  <= 1'b0;
                    end
                    ACQUIRE: begin
                        goodCnt_r <= GOOD_ZERO;
                        locked_r  <= 1'b0;
                        if (divRise_s) begin
                            state_r <= CHECK;
                        end else begin
                            state_r <= ACQUIRE;
                        end
                    end
                    CHECK: begin
                        if (bad_s) begin
                            goodCnt_r <= GOOD_ZERO;
                            state_r   <= CHECK;
                            locked_r  <= 1'b0;
                        end else if (good_s && (goodCnt_r == GOOD_LAST)) begin
                            goodCnt_r <= goodCnt_r + GOOD_ONE;
                            state_r   <= LOCKED;
                            locked_r  <= 1'b1;
                        end else if (good_s) begin
                            goodCnt_r <= goodCnt_r + GOOD_ONE;
                            state_r   <= CHECK;
                            locked_r  <= 1'b0;
                        end else begin
                            state_r   <= CHECK;
                            locked_r  <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (bad_s) begin
                            goodCnt_r <= GOOD_ZERO;
                            state_r   <= CHECK;
                            locked_r  <= 1'b0;
                        end else begin
                            state_r   <= LOCKED;
                            locked_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        goodCnt_r <= GOOD_ZERO;
                        locked_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign edgeStrobe = divRise_s;
    assign periodOut  = periodOut_r;
    assign highOut    = highOut_r;
    assign locked     = locked_r;
    assign fault      = fault_r;

endmodule
